// File: rtl/accum_alu_if.sv
// Operand/opcode handshake and result bus between the accum_alu datapath and its neighbours.
// The master drives transactions in; the slave (accum_alu) returns the accumulator and a result strobe.
interface accum_alu_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc;
  logic             out_valid;

  modport master (
    output in_valid,
    output op,
    output operand,
    input  in_ready,
    input  acc,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  op,
    input  operand,
    output in_ready,
    output acc,
    output out_valid
  );
endinterface

// File: rtl/accum_alu.sv
// Accumulator ALU: one op per accepted transaction, iterative shift-add multiply,
// sticky ERROR state on overflow (wrap or saturate selectable).
module accum_alu #(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        on,
  input  logic        clr_err,
  accum_alu_if.slave  bus,
  output logic        overflow,
  output logic [1:0]  state
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [2:0] OpAnd  = 3'd0;
  localparam logic [2:0] OpOr   = 3'd1;
  localparam logic [2:0] OpNot  = 3'd2;
  localparam logic [2:0] OpXor  = 3'd3;
  localparam logic [2:0] OpAdd  = 3'd4;
  localparam logic [2:0] OpSub  = 3'd5;
  localparam logic [2:0] OpMul  = 3'd6;
  localparam logic [2:0] OpLoad = 3'd7;

  typedef enum logic [1:0] {
    StOff   = 2'b00,
    StReady = 2'b01,
    StRun   = 2'b10,
    StError = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               out_valid_q, out_valid_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic [2*WIDTH-1:0] prod_sum;
  logic               mul_ovf;
  logic [WIDTH-1:0]   mul_res;

  assign sum  = {1'b0, acc_q} + {1'b0, bus.operand};
  assign diff = {1'b0, acc_q} - {1'b0, bus.operand};

  // One shift-add step; the multiplicand shifts left as the multiplier shifts right.
  assign prod_sum = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_ovf  = |prod_sum[2*WIDTH-1:WIDTH];
  assign mul_res  = (mul_ovf && SATURATE) ? '1 : prod_sum[WIDTH-1:0];

  always_comb begin
    alu_res = acc_q;
    alu_ovf = 1'b0;
    unique case (bus.op)
      OpAnd:  alu_res = acc_q & bus.operand;
      OpOr:   alu_res = acc_q | bus.operand;
      OpNot:  alu_res = ~acc_q;
      OpXor:  alu_res = acc_q ^ bus.operand;
      OpAdd: begin
        alu_ovf = sum[WIDTH];
        alu_res = (alu_ovf && SATURATE) ? '1 : sum[WIDTH-1:0];
      end
      OpSub: begin
        alu_ovf = diff[WIDTH];
        alu_res = (alu_ovf && SATURATE) ? '0 : diff[WIDTH-1:0];
      end
      OpMul:  alu_res = acc_q;
      OpLoad: alu_res = bus.operand;
    endcase
  end

  assign bus.in_ready  = (state_q == StReady) && on;
  assign bus.acc       = acc_q;
  assign bus.out_valid = out_valid_q;
  assign overflow      = (state_q == StError);
  assign state         = state_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    unique case (state_q)
      StOff: begin
        if (on) state_d = StReady;
      end
      StReady: begin
        if (!on) begin
          state_d = StOff;
        end else if (bus.in_valid) begin
          if (bus.op == OpMul) begin
            state_d  = StRun;
            cnt_d    = '0;
            prod_d   = '0;
            mcand_d  = {{WIDTH{1'b0}}, acc_q};
            mplier_d = bus.operand;
          end else begin
            acc_d       = alu_res;
            out_valid_d = 1'b1;
            state_d     = alu_ovf ? StError : StReady;
          end
        end
      end
      StRun: begin
        prod_d   = prod_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          cnt_d       = '0;
          acc_d       = mul_res;
          out_valid_d = 1'b1;
          state_d     = mul_ovf ? StError : StReady;
        end
      end
      StError: begin
        if (clr_err) state_d = StReady;
      end
      default: state_d = StOff;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StOff;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
    end
  end

endmodule

// File: tb/tb_accum_alu.sv
// Scoreboard bench for accum_alu: a wrapping and a saturating instance run the same stimulus,
// each result strobe is checked against the expectation queued when the transaction was issued.
module tb_accum_alu;

  localparam logic [2:0] OpAnd  = 3'd0;
  localparam logic [2:0] OpOr   = 3'd1;
  localparam logic [2:0] OpNot  = 3'd2;
  localparam logic [2:0] OpXor  = 3'd3;
  localparam logic [2:0] OpAdd  = 3'd4;
  localparam logic [2:0] OpSub  = 3'd5;
  localparam logic [2:0] OpMul  = 3'd6;
  localparam logic [2:0] OpLoad = 3'd7;

  logic       clk = 1'b0;
  logic       rst, on, clr_err, in_valid;
  logic [2:0] op;
  logic [7:0] operand;
  logic       ovf0, ovf1;
  logic [1:0] st0, st1;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  accum_alu_if #(.WIDTH(8)) if0 ();
  accum_alu_if #(.WIDTH(8)) if1 ();

  assign if0.in_valid = in_valid;
  assign if0.op       = op;
  assign if0.operand  = operand;
  assign if1.in_valid = in_valid;
  assign if1.op       = op;
  assign if1.operand  = operand;

  accum_alu #(.WIDTH(8), .SATURATE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .on(on), .clr_err(clr_err), .bus(if0), .overflow(ovf0), .state(st0)
  );
  accum_alu #(.WIDTH(8), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .on(on), .clr_err(clr_err), .bus(if1), .overflow(ovf1), .state(st1)
  );

  typedef struct packed {
    logic [7:0] acc;
    logic [1:0] st;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] m_acc0, m_acc1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                                input bit sat, output logic [7:0] r, output bit ovf);
    logic [8:0]  s;
    logic [15:0] p;
    ovf = 1'b0;
    r   = a;
    case (o)
      OpAnd:  r = a & b;
      OpOr:   r = a | b;
      OpNot:  r = ~a;
      OpXor:  r = a ^ b;
      OpAdd: begin
        s = {1'b0, a} + {1'b0, b};
        ovf = s[8];
        r = (ovf && sat) ? 8'hFF : s[7:0];
      end
      OpSub: begin
        ovf = (b > a);
        r = (ovf && sat) ? 8'h00 : 8'(a - b);
      end
      OpMul: begin
        p = {8'h00, a} * {8'h00, b};
        ovf = |p[15:8];
        r = (ovf && sat) ? 8'hFF : p[7:0];
      end
      default: r = b;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (if0.out_valid === 1'b1) begin
      if (q0.size() == 0) check("dut0_unexpected_valid", 1, 0);
      else begin
        e = q0.pop_front();
        check("dut0_result_acc", if0.acc, e.acc);
        check("dut0_result_state", st0, e.st);
      end
    end
    if (if1.out_valid === 1'b1) begin
      if (q1.size() == 0) check("dut1_unexpected_valid", 1, 0);
      else begin
        e = q1.pop_front();
        check("dut1_result_acc", if1.acc, e.acc);
        check("dut1_result_state", st1, e.st);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [7:0] b);
    int w = 0;
    logic [7:0] r0, r1;
    bit v0, v1;
    while (!(if0.in_ready && if1.in_ready) && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      check("ready_timeout", 0, 1);
    end else begin
      in_valid = 1'b1;
      op       = o;
      operand  = b;
      model(o, m_acc0, b, 1'b0, r0, v0);
      model(o, m_acc1, b, 1'b1, r1, v1);
      q0.push_back('{acc: r0, st: v0 ? 2'b11 : 2'b01});
      q1.push_back('{acc: r1, st: v1 ? 2'b11 : 2'b01});
      m_acc0 = r0;
      m_acc1 = r1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic clear();
    clr_err = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_err = 1'b0;
    check("clr_err_state0", st0, 2'b01);
    check("clr_err_state1", st1, 2'b01);
  endtask

  task automatic wait_run(output int n);
    int rdy_hi = 0;
    n = 0;
    while (st0 == 2'b10 && n < 40) begin
      if (if0.in_ready !== 1'b0) rdy_hi++;
      n++;
      @(negedge clk);
    end
    check("run_in_ready_low", rdy_hi, 0);
  endtask

  initial begin
    int t0, n;
    rst = 1'b1; on = 1'b0; clr_err = 1'b0; in_valid = 1'b0; op = '0; operand = '0;
    m_acc0 = '0; m_acc1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", st0, 2'b00);
    check("rst_acc", if0.acc, 8'h00);
    check("rst_out_valid", if0.out_valid, 1'b0);
    check("rst_overflow", ovf0, 1'b0);
    check("rst_in_ready", if0.in_ready, 1'b0);

    rst = 1'b0; on = 1'b1;
    @(negedge clk);
    check("on_ready", st0, 2'b01);
    issue(OpLoad, 8'h35);
    check("load_acc", if0.acc, 8'h35);
    @(negedge clk);
    check("load_single_pulse", if0.out_valid, 1'b0);

    issue(OpLoad, 8'h0F);
    t0 = cyc;
    issue(OpAnd, 8'h3C);
    issue(OpOr, 8'hF0);
    issue(OpXor, 8'hFF);
    issue(OpNot, 8'h00);
    check("b2b_cycles", cyc - t0, 4);
    check("logic_chain_acc", if0.acc, 8'hFC);

    issue(OpLoad, 8'hF0);
    issue(OpAdd, 8'h20);
    check("add_wrap_acc", if0.acc, 8'h10);
    check("add_sat_acc", if1.acc, 8'hFF);
    check("add_err_state", st0, 2'b11);
    check("add_overflow", ovf0, 1'b1);
    check("add_err_in_ready", if0.in_ready, 1'b0);
    clear();
    check("clr_acc_kept", if0.acc, 8'h10);

    issue(OpLoad, 8'h10);
    issue(OpSub, 8'h11);
    check("sub_wrap_acc", if0.acc, 8'hFF);
    check("sub_sat_acc", if1.acc, 8'h00);
    check("sub_err_state", st0, 2'b11);
    clear();

    issue(OpLoad, 8'h0C);
    issue(OpMul, 8'h0B);
    operand = 8'hFF;
    check("mul_acc_held", if0.acc, 8'h0C);
    wait_run(n);
    check("mul_run_cycles", n, 8);
    check("mul_acc", if0.acc, 8'h84);
    check("mul_state", st0, 2'b01);
    issue(OpMul, 8'h02);
    wait_run(n);
    check("mul_ovf_wrap_acc", if0.acc, 8'h08);
    check("mul_ovf_sat_acc", if1.acc, 8'hFF);
    check("mul_ovf_state", st0, 2'b11);
    clear();

    issue(OpLoad, 8'h03);
    issue(OpMul, 8'h05);
    on = 1'b0;
    wait_run(n);
    check("on0_run_cycles", n, 8);
    check("on0_run_ready", st0, 2'b01);
    check("on0_run_acc", if0.acc, 8'h0F);
    @(negedge clk);
    check("on0_then_off", st0, 2'b00);
    on = 1'b1;
    @(negedge clk);
    check("back_ready", st0, 2'b01);

    on = 1'b0; in_valid = 1'b1; op = OpLoad; operand = 8'hAA;
    @(negedge clk);
    check("off_no_accept_state", st0, 2'b00);
    check("off_no_accept_acc", if0.acc, m_acc0);
    in_valid = 1'b0; on = 1'b1;
    @(negedge clk);

    issue(OpLoad, 8'h0C);
    issue(OpMul, 8'h0B);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    q0.delete();
    q1.delete();
    m_acc0 = '0;
    m_acc1 = '0;
    @(negedge clk);
    check("rst_run_state", st0, 2'b00);
    check("rst_run_acc", if0.acc, 8'h00);
    check("rst_run_out_valid", if0.out_valid, 1'b0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_run_recover", st0, 2'b01);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
